// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the RV32IM fetch front end
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry {pc, instr} holding register for stalled responses
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_instr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buf_pc    <= DEFAULT_RESET_PC;
            buf_instr <= NOP_INSTR;
        end else if (load) begin
            buf_pc    <= load_pc;
            buf_instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC ownership, imem requests, stall buffering and redirect squash
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    fetch_state_t state;
    logic [31:0]  fpc;
    logic [31:0]  fpc_next;
    logic [31:0]  target;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;
    logic         buf_load;
    logic         buf_clear;

    assign target   = word_align(redirect_pc);
    assign fpc_next = fpc + 32'd4;

    // A response can only be parked when the downstream still holds an unconsumed instruction.
    assign buf_load  = (state == WAIT) && !redirect && imem_valid && valid_out && stall;
    assign buf_clear = (state == HOLD) && (redirect || !stall);

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (fpc),
        .load_instr (imem_rdata),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            pc_out    <= RESET_PC;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= WAIT;
                    imem_req  <= 1'b1;
                    imem_addr <= fpc;
                end
                WAIT: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                        fpc       <= target;
                        if (imem_valid) begin
                            imem_req  <= 1'b1;
                            imem_addr <= target;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_valid && valid_out && stall) begin
                        state <= HOLD;
                    end else if (imem_valid) begin
                        pc_out    <= fpc;
                        instr_out <= imem_rdata;
                        valid_out <= 1'b1;
                        fpc       <= fpc_next;
                        imem_req  <= 1'b1;
                        imem_addr <= fpc_next;
                    end else if (valid_out && !stall) begin
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                        fpc       <= target;
                        imem_req  <= 1'b1;
                        imem_addr <= target;
                        state     <= WAIT;
                    end else if (!stall) begin
                        pc_out    <= buf_pc;
                        instr_out <= buf_instr;
                        valid_out <= 1'b1;
                        fpc       <= fpc_next;
                        imem_req  <= 1'b1;
                        imem_addr <= fpc_next;
                        state     <= WAIT;
                    end
                end
                DROP: begin
                    // A redirect coinciding with the stale response still wins: fetch its target directly.
                    if (imem_valid) begin
                        imem_req  <= 1'b1;
                        imem_addr <= redirect ? target : fpc;
                        if (redirect) begin
                            fpc <= target;
                        end
                        state <= WAIT;
                    end else if (redirect) begin
                        fpc <= target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    int checks = 0;
    int failures = 0;

    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Instruction memory: fixed latency, in order, one outstanding.
    initial forever begin
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(pend_addr);
            end
        end
        if (imem_req) begin
            pend_cnt  = mem_lat;
            pend_addr = imem_addr;
        end
    end

    // Reference model: the stream of presented instructions must walk the program order.
    logic        prev_rst = 1'b1;
    logic        prev_stall = 1'b0;
    logic        prev_redirect = 1'b0;
    logic [31:0] prev_redirect_pc = 32'h0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic        outstanding = 1'b0;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_valid_out", valid_out, 0);
            chk("rst_instr_out", instr_out, NOP_INSTR);
            chk("rst_pc_out", pc_out, TB_RESET_PC);
            chk("rst_imem_req", imem_req, 0);
            chk("rst_imem_addr", imem_addr, TB_RESET_PC);
            exp_pc      = TB_RESET_PC;
            outstanding = 1'b0;
        end else begin
            if (!valid_out) chk("nop_when_invalid", instr_out, NOP_INSTR);
            if (imem_req) begin
                chk("req_aligned", imem_addr[1:0], 0);
                chk("req_while_outstanding", outstanding, 0);
                outstanding = 1'b1;
            end
            if (imem_valid) outstanding = 1'b0;
            if (prev_redirect) begin
                chk("squash_valid_out", valid_out, 0);
                exp_pc = {prev_redirect_pc[31:2], 2'b00};
            end else if (prev_valid && prev_stall) begin
                chk("stall_valid_out", valid_out, 1);
                chk("stall_pc_out", pc_out, prev_pc);
                chk("stall_instr_out", instr_out, prev_instr);
            end else if (valid_out) begin
                chk("seq_pc_out", pc_out, exp_pc);
                chk("seq_instr_out", instr_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        prev_rst         = rst;
        prev_stall       = stall;
        prev_redirect    = redirect;
        prev_redirect_pc = redirect_pc;
        prev_valid       = valid_out;
        prev_pc          = pc_out;
        prev_instr       = instr_out;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return valid_out;
            1:       return imem_valid;
            default: return imem_req;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int n;
        n = 0;
        while (!sig_sel(which) && n < 40) begin
            step();
            n++;
        end
        chk(name, (n < 40), 1);
    endtask

    initial begin
        repeat (3) step();
        chk("t1_reset_valid", valid_out, 0);
        chk("t1_reset_instr", instr_out, 32'h0000_0013);
        chk("t1_reset_req", imem_req, 0);
        rst = 1'b0;
        step();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        step();
        step();
        chk("t1_valid", valid_out, 1);
        chk("t1_pc", pc_out, 32'h0);
        chk("t1_instr", instr_out, 32'h0050_0093);
        chk("t1_next_req", imem_req, 1);
        chk("t1_next_addr", imem_addr, 32'h4);

        // Stall for three cycles across the arrival of the pc 4 response.
        stall = 1'b1;
        repeat (3) step();
        chk("t2_held_valid", valid_out, 1);
        chk("t2_held_pc", pc_out, 32'h0);
        chk("t2_hold_no_req", imem_req, 0);
        stall = 1'b0;
        step();
        chk("t2_buf_pc", pc_out, 32'h4);
        chk("t2_buf_instr", instr_out, 32'hA5A5_0004);
        chk("t2_next_req", imem_req, 1);
        chk("t2_next_addr", imem_addr, 32'h8);
        repeat (6) step();

        // Redirect while a 3-cycle request is outstanding.
        mem_lat = 3;
        step();
        wait_for(2, "t3_wait_req");
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("t3_squash_valid", valid_out, 0);
        chk("t3_squash_instr", instr_out, 32'h0000_0013);
        repeat (3) step();
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h100);
        wait_for(0, "t3_wait_valid");
        chk("t3_pc", pc_out, 32'h100);
        chk("t3_instr", instr_out, 32'hA5A5_0100);

        // Redirect coinciding with a response, then a double redirect through DROP.
        wait_for(1, "t4_wait_resp");
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
        redirect_pc = 32'h280;
        step();
        chk("t4_drop_req", imem_req, 0);
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        step();
        step();
        chk("t4_latest_req", imem_req, 1);
        chk("t4_latest_addr", imem_addr, 32'h300);
        wait_for(0, "t4_wait_valid");
        chk("t4_pc", pc_out, 32'h300);

        // Misaligned redirect target and PC wrap.
        mem_lat = 1;
        wait_for(1, "t5_wait_resp");
        redirect = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        chk("t5_align_req", imem_req, 1);
        chk("t5_align_addr", imem_addr, 32'h100);
        wait_for(0, "t5_wait_valid");
        chk("t5_align_pc", pc_out, 32'h100);
        wait_for(1, "t5_wait_resp2");
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_for(0, "t5_wait_top");
        chk("t5_top_pc", pc_out, 32'hFFFF_FFFC);
        chk("t5_top_instr", instr_out, 32'h5A5A_FFFC);
        chk("t5_wrap_req", imem_req, 1);
        chk("t5_wrap_addr", imem_addr, 32'h0);
        repeat (4) step();

        // Reset while holding a buffered response.
        wait_for(0, "t6_wait_valid");
        stall = 1'b1;
        step();
        step();
        chk("t6_hold_valid", valid_out, 1);
        chk("t6_hold_no_req", imem_req, 0);
        rst = 1'b1;
        step();
        chk("t6_hold_rst_valid", valid_out, 0);
        chk("t6_hold_rst_req", imem_req, 0);
        rst = 1'b0;
        stall = 1'b0;
        step();
        chk("t6_hold_restart_req", imem_req, 1);
        chk("t6_hold_restart_addr", imem_addr, 32'h0);

        // Reset in DROP; the stale response lands while the unit is idle.
        mem_lat = 3;
        step();
        wait_for(2, "t6_wait_req");
        redirect = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        chk("t6_drop_valid", valid_out, 0);
        rst = 1'b1;
        step();
        for (int n = 0; n < 10 && pend_cnt > 0; n++) step();
        rst = 1'b0;
        chk("t6_stale_arrives", imem_valid, 1);
        step();
        chk("t6_drop_restart_req", imem_req, 1);
        chk("t6_drop_restart_addr", imem_addr, 32'h0);
        chk("t6_stale_ignored", valid_out, 0);
        wait_for(0, "t6_wait_first");
        chk("t6_first_pc", pc_out, 32'h0);
        chk("t6_first_instr", instr_out, 32'h0050_0093);
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
